// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage RISC-V pipeline.
//
// Takes the EX/MEM register fields (ALU result, store data, rd, control bits),
// drives the processor side of the data cache, freezes the front of the
// pipeline while a cache access is outstanding, and registers the write-back
// value into the MEM/WB register.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   alu_result_in     byte address for loads/stores, result for ALU ops
//   second_opr_in     store data (rs2)
//   rd_in             destination register
//   memrd_in/memwr_in load / store
//   mem2reg_in        write-back selects memory data
//   regwr_in          register write enable
//   dmem_read/write   cache request (read wins if both set)
//   dmem_addr         word address to the cache
//   dmem_wdata        store data to the cache
//   dmem_rdata        load data from the cache, valid when dmem_stall=0
//   dmem_stall        cache busy, combinational from the request
//   stall_out         freezes PC, IF/ID, ID/EX and EX/MEM
//   wb_data_out       registered write-back value
//   rd_out            registered rd
//   regwr_out         registered write enable
//   misalign_err      one-cycle pulse on a misaligned access
//   stall_cnt         saturating count of cycles with stall_out high
//   dbg_busy          FSM state (1 = BUSY), for observation only
//
// Handshake: a request is presented when dmem_read or dmem_write is high.
// The cache accepts and completes it in the same cycle when dmem_stall is
// low; while dmem_stall is high the request (address, data, direction) is
// held stable until the first cycle in which dmem_stall is low, which is the
// completion cycle. dmem_stall is meaningless when no request is presented.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int BIT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BIT_W-1:0]   alu_result_in,
  input  logic [BIT_W-1:0]   second_opr_in,
  input  logic [4:0]         rd_in,
  input  logic               memrd_in,
  input  logic               memwr_in,
  input  logic               mem2reg_in,
  input  logic               regwr_in,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [BIT_W-3:0]   dmem_addr,
  output logic [BIT_W-1:0]   dmem_wdata,
  input  logic [BIT_W-1:0]   dmem_rdata,
  input  logic               dmem_stall,
  output logic               stall_out,
  output logic [BIT_W-1:0]   wb_data_out,
  output logic [4:0]         rd_out,
  output logic               regwr_out,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               dbg_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Latched copy of the request that missed; the only source in BUSY.
  logic             req_rd_q,     req_rd_d;
  logic             req_wr_q,     req_wr_d;
  logic [BIT_W-1:0] req_alu_q,    req_alu_d;
  logic [BIT_W-1:0] req_wdata_q,  req_wdata_d;
  logic [4:0]       req_rdidx_q,  req_rdidx_d;
  logic             req_m2r_q,    req_m2r_d;
  logic             req_rw_q,     req_rw_d;

  // MEM/WB register and status flops.
  logic [BIT_W-1:0] wb_data_q,    wb_data_d;
  logic [4:0]       rd_q,         rd_d;
  logic             regwr_q,      regwr_d;
  logic             misalign_q,   misalign_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

  // Decode of the incoming instruction.
  logic mem_op;
  logic aligned;
  logic access;
  logic misalign_now;

  // Currently selected source (inputs in IDLE, latched copy in BUSY).
  logic             cur_active;
  logic             cur_rd;
  logic             cur_wr;
  logic [BIT_W-1:0] cur_alu;
  logic [BIT_W-1:0] cur_wdata;
  logic [4:0]       cur_rdidx;
  logic             cur_m2r;
  logic             cur_rw;
  logic             stall;

  assign mem_op       = memrd_in | memwr_in;
  assign aligned      = (alu_result_in[1:0] == 2'b00);
  assign access       = mem_op & aligned;
  assign misalign_now = (state_q == IDLE) & mem_op & ~aligned;

  // Source selection and next-state logic.
  always_comb begin
    state_d    = state_q;
    cur_active = 1'b0;
    cur_rd     = 1'b0;
    cur_wr     = 1'b0;
    cur_alu    = alu_result_in;
    cur_wdata  = second_opr_in;
    cur_rdidx  = rd_in;
    cur_m2r    = mem2reg_in;
    cur_rw     = regwr_in;

    unique case (state_q)
      IDLE: begin
        cur_active = access;
        cur_rd     = memrd_in;
        cur_wr     = memwr_in & ~memrd_in;
        if (access && dmem_stall) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        cur_active = 1'b1;
        cur_rd     = req_rd_q;
        cur_wr     = req_wr_q;
        cur_alu    = req_alu_q;
        cur_wdata  = req_wdata_q;
        cur_rdidx  = req_rdidx_q;
        cur_m2r    = req_m2r_q;
        cur_rw     = req_rw_q;
        if (!dmem_stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // dmem_stall only matters while a request is actually presented.
  assign stall = cur_active & dmem_stall;

  // Request outputs are gated by rst_n so they drop the instant reset is
  // asserted, even if the upstream stage still presents a load/store.
  assign dmem_read  = rst_n & cur_active & cur_rd;
  assign dmem_write = rst_n & cur_active & cur_wr;
  assign dmem_addr  = cur_alu[BIT_W-1:2];
  assign dmem_wdata = cur_wdata;
  assign stall_out  = rst_n & stall;

  // Request latch: captured only on the IDLE cycle that first stalls.
  always_comb begin
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    req_alu_d   = req_alu_q;
    req_wdata_d = req_wdata_q;
    req_rdidx_d = req_rdidx_q;
    req_m2r_d   = req_m2r_q;
    req_rw_d    = req_rw_q;
    if ((state_q == IDLE) && access && dmem_stall) begin
      req_rd_d    = memrd_in;
      req_wr_d    = memwr_in & ~memrd_in;
      req_alu_d   = alu_result_in;
      req_wdata_d = second_opr_in;
      req_rdidx_d = rd_in;
      req_m2r_d   = mem2reg_in;
      req_rw_d    = regwr_in;
    end
  end

  // MEM/WB update: a stall inserts a bubble (write enable low, data and rd
  // held); otherwise the selected instruction retires into the register.
  always_comb begin
    wb_data_d   = wb_data_q;
    rd_d        = rd_q;
    regwr_d     = 1'b0;
    misalign_d  = 1'b0;
    stall_cnt_d = stall_cnt_q;

    if (stall) begin
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      wb_data_d  = cur_m2r ? dmem_rdata : cur_alu;
      rd_d       = cur_rdidx;
      // x0 is never written; a misaligned access is squashed.
      regwr_d    = cur_rw & (cur_rdidx != 5'd0) & ~misalign_now;
      misalign_d = misalign_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_rd_q     <= 1'b0;
      req_wr_q     <= 1'b0;
      req_alu_q    <= '0;
      req_wdata_q  <= '0;
      req_rdidx_q  <= '0;
      req_m2r_q    <= 1'b0;
      req_rw_q     <= 1'b0;
      wb_data_q    <= '0;
      rd_q         <= '0;
      regwr_q      <= 1'b0;
      misalign_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_rd_q     <= req_rd_d;
      req_wr_q     <= req_wr_d;
      req_alu_q    <= req_alu_d;
      req_wdata_q  <= req_wdata_d;
      req_rdidx_q  <= req_rdidx_d;
      req_m2r_q    <= req_m2r_d;
      req_rw_q     <= req_rw_d;
      wb_data_q    <= wb_data_d;
      rd_q         <= rd_d;
      regwr_q      <= regwr_d;
      misalign_q   <= misalign_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign wb_data_out  = wb_data_q;
  assign rd_out       = rd_q;
  assign regwr_out    = regwr_q;
  assign misalign_err = misalign_q;
  assign stall_cnt    = stall_cnt_q;
  assign dbg_busy     = (state_q == BUSY);

endmodule
